// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl
// Sequencing controller for an iterative AES-128 encryptor.
// Holds the cipher state, the previous round key and the round counter.
// Drives one round per clock through an external combinational datapath.
// Returns the ciphertext with a valid/ready handshake.
// Optional feature: define AES_CTRL_ABORT_EN to add an 'abort' input.
// That input cancels an operation that is running or waiting to be read.
module aes_round_ctrl #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst_n,
`ifdef AES_CTRL_ABORT_EN
  input  logic         abort,
`endif
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] pt,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] ct,
  output logic         busy,
  output logic [127:0] dp_state,
  output logic [127:0] dp_key,
  output logic [3:0]   dp_round_num,
  output logic         dp_last,
  input  logic [127:0] dp_state_in,
  input  logic [127:0] dp_key_in
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

  logic [1:0]   fsm_state;
  logic [1:0]   fsm_next;
  logic [127:0] state_reg;
  logic [127:0] key_reg;
  logic [3:0]   round;

  logic accept;
  logic emit;
  logic finish_run;
  logic abort_hit;
  logic running;

  assign running    = (fsm_state == ST_RUN);
  assign accept     = in_valid && (fsm_state == ST_IDLE);
  assign emit       = out_ready && (fsm_state == ST_DONE);
  assign finish_run = running && (round == LAST_ROUND);

  // An abort only matters once an operation is in flight.
  // In IDLE it is ignored, so a coincident request is still accepted.
`ifdef AES_CTRL_ABORT_EN
  assign abort_hit = abort && (fsm_state != ST_IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  // Next-state logic for the three-state sequencer; abort overrides every other transition.
  always_comb begin
    fsm_next = fsm_state;
    case (fsm_state)
      ST_IDLE: if (accept)     fsm_next = ST_RUN;
      ST_RUN:  if (finish_run) fsm_next = ST_DONE;
      ST_DONE: if (emit)       fsm_next = ST_IDLE;
      default:                 fsm_next = ST_IDLE;
    endcase
    if (abort_hit) begin
      fsm_next = ST_IDLE;
    end
  end

  // State register for the sequencer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_state <= ST_IDLE;
    end else begin
      fsm_state <= fsm_next;
    end
  end

  // Cipher state, round key and round counter.
  // They load on a request, advance once per RUN cycle and otherwise hold.
  // The counter stops at the final round so it never passes NUM_ROUNDS.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= '0;
      key_reg   <= '0;
      round     <= '0;
    end else if (abort_hit) begin
      state_reg <= '0;
      key_reg   <= '0;
      round     <= '0;
    end else if (accept) begin
      state_reg <= pt ^ key;
      key_reg   <= key;
      round     <= 4'd1;
    end else if (running) begin
      state_reg <= dp_state_in;
      key_reg   <= dp_key_in;
      if (!finish_run) begin
        round <= round + 4'd1;
      end
    end
  end

  assign in_ready     = (fsm_state == ST_IDLE);
  assign busy         = (fsm_state == ST_RUN) || (fsm_state == ST_DONE);
  assign out_valid    = (fsm_state == ST_DONE);
  assign ct           = out_valid ? state_reg : '0;

  assign dp_state     = state_reg;
  assign dp_key       = key_reg;
  assign dp_round_num = round;
  assign dp_last      = running && (round == LAST_ROUND);

endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb_aes_round_ctrl
// Directed bench for aes_round_ctrl.
// A behavioural AES-128 round and key-schedule datapath is wired to the dp_* ports.
// Results are compared against the FIPS-197 example vectors.
// Define AES_CTRL_ABORT_EN to also exercise the abort input.
module tb_aes_round_ctrl;

  localparam logic [127:0] KEY_A = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_A  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_A  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] ARK_A = 128'h00102030405060708090a0b0c0d0e0f0;
  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;

  logic         clk;
  logic         rst_n;
`ifdef AES_CTRL_ABORT_EN
  logic         abort;
`endif
  logic         in_valid;
  logic         in_ready;
  logic [127:0] pt;
  logic [127:0] key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] ct;
  logic         busy;
  logic [127:0] dp_state;
  logic [127:0] dp_key;
  logic [3:0]   dp_round_num;
  logic         dp_last;
  logic [127:0] dp_state_in;
  logic [127:0] dp_key_in;

  int passed = 0;
  int total  = 0;

  aes_round_ctrl #(.NUM_ROUNDS(10)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
`ifdef AES_CTRL_ABORT_EN
    .abort        (abort),
`endif
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .pt           (pt),
    .key          (key),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .ct           (ct),
    .busy         (busy),
    .dp_state     (dp_state),
    .dp_key       (dp_key),
    .dp_round_num (dp_round_num),
    .dp_last      (dp_last),
    .dp_state_in  (dp_state_in),
    .dp_key_in    (dp_key_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // S-box from the GF(2^8) inverse (b^254) followed by the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] inv;
    inv = 8'h00;
    if (b != 8'h00) begin
      inv = 8'h01;
      for (int i = 0; i < 254; i++) inv = gmul(inv, b);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  // Next round key: takes the previous round key and the round number (1..10).
  function automatic logic [127:0] aes_next_key(input logic [127:0] k, input logic [3:0] rnd);
    logic [31:0] w0, w1, w2, w3, t;
    logic [7:0]  rc;
    {w0, w1, w2, w3} = k;
    rc = 8'h01;
    for (int i = 1; i < int'(rnd); i++) rc = xtime(rc);
    t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rc, 24'h0};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // One cipher round: SubBytes, ShiftRows, MixColumns (skipped when last) and AddRoundKey.
  function automatic logic [127:0] aes_round(input logic [127:0] st, input logic last,
                                             input logic [127:0] rk);
    logic [7:0]   a [16];
    logic [7:0]   b [16];
    logic [7:0]   s0, s1, s2, s3;
    logic [127:0] r;
    for (int i = 0; i < 16; i++) a[i] = sbox(st[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int rr = 0; rr < 4; rr++)
        b[rr + 4*c] = a[rr + 4*((c + rr) % 4)];
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        s0 = b[4*c]; s1 = b[4*c+1]; s2 = b[4*c+2]; s3 = b[4*c+3];
        b[4*c]   = xtime(s0) ^ xtime(s1) ^ s1 ^ s2 ^ s3;
        b[4*c+1] = s0 ^ xtime(s1) ^ xtime(s2) ^ s2 ^ s3;
        b[4*c+2] = s0 ^ s1 ^ xtime(s2) ^ xtime(s3) ^ s3;
        b[4*c+3] = xtime(s0) ^ s0 ^ s1 ^ s2 ^ xtime(s3);
      end
    end
    r = '0;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = b[i] ^ rk[127-8*i -: 8];
    return r;
  endfunction

  // Behavioural round datapath feeding the controller.
  always_comb begin
    dp_key_in   = aes_next_key(dp_key, dp_round_num);
    dp_state_in = aes_round(dp_state, dp_last, dp_key_in);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [127:0] observed,
                              input logic [127:0] expected);
    total++;
    assert (observed === expected) passed++;
    else $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
  endtask

  // Presents one request for a single edge; on return the bench is in cycle 1.
  task automatic apply_stimulus(input logic [127:0] p, input logic [127:0] k);
    in_valid = 1'b1;
    pt       = p;
    key      = k;
    tick();
    in_valid = 1'b0;
  endtask

  // Waits (bounded) for out_valid, then checks the latency and the ciphertext.
  task automatic wait_for_output(input string tag, input logic [127:0] exp_ct);
    int cyc;
    cyc = 1;
    while (out_valid !== 1'b1 && cyc < 40) begin
      tick();
      cyc++;
    end
    check_output({tag, "_latency"}, 128'(cyc), 128'(11));
    check_output({tag, "_ct"}, ct, exp_ct);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    pt        = '0;
    key       = '0;
`ifdef AES_CTRL_ABORT_EN
    abort     = 1'b0;
`endif
    #1;
    check_output("rst_in_ready",  128'(in_ready),     128'(1));
    check_output("rst_out_valid", 128'(out_valid),    128'(0));
    check_output("rst_busy",      128'(busy),         128'(0));
    check_output("rst_ct",        ct,                 128'(0));
    check_output("rst_dp_last",   128'(dp_last),      128'(0));
    check_output("rst_round",     128'(dp_round_num), 128'(0));
    check_output("rst_dp_state",  dp_state,           128'(0));
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // FIPS-197 C.1 vector, with an extra request at cycle 4 that must be ignored.
    apply_stimulus(PT_A, KEY_A);
    check_output("a_busy",      128'(busy),     128'(1));
    check_output("a_in_ready",  128'(in_ready), 128'(0));
    check_output("a_ark_state", dp_state,       ARK_A);
    check_output("a_dp_key",    dp_key,         KEY_A);
    for (int c = 1; c <= 10; c++) begin
      check_output($sformatf("a_round_num_%0d", c), 128'(dp_round_num), 128'(c));
      check_output($sformatf("a_dp_last_%0d", c),   128'(dp_last),      128'(c == 10));
      check_output($sformatf("a_no_valid_%0d", c),  128'(out_valid),    128'(0));
      check_output($sformatf("a_ct_zero_%0d", c),   ct,                 128'(0));
      if (c == 4) begin
        in_valid = 1'b1;
        pt       = PT_B;
      end else begin
        in_valid = 1'b0;
      end
      tick();
    end
    check_output("a_out_valid_c11", 128'(out_valid), 128'(1));
    check_output("a_ct",            ct,              CT_A);
    check_output("a_done_dp_last",  128'(dp_last),   128'(0));
    check_output("a_done_round",    128'(dp_round_num), 128'(10));
    tick();
    check_output("a_ready_after",   128'(in_ready),  128'(1));
    check_output("a_valid_after",   128'(out_valid), 128'(0));
    check_output("a_ct_after",      ct,              128'(0));

    // FIPS-197 Appendix B vector with the consumer stalling for five cycles.
    out_ready = 1'b0;
    apply_stimulus(PT_B, KEY_B);
    wait_for_output("b", CT_B);
    for (int k = 0; k < 6; k++) begin
      check_output($sformatf("b_hold_ct_%0d", k),    ct,              CT_B);
      check_output($sformatf("b_hold_valid_%0d", k), 128'(out_valid), 128'(1));
      check_output($sformatf("b_hold_busy_%0d", k),  128'(busy),      128'(1));
      if (k == 5) out_ready = 1'b1;
      tick();
    end
    check_output("b_ready_after", 128'(in_ready),  128'(1));
    check_output("b_valid_after", 128'(out_valid), 128'(0));

    // Reset in the middle of a run, then a fresh request right after release.
    apply_stimulus(PT_A, KEY_A);
    for (int c = 1; c < 5; c++) tick();
    rst_n = 1'b0;
    #1;
    check_output("c_rst_valid",    128'(out_valid),    128'(0));
    check_output("c_rst_ct",       ct,                 128'(0));
    check_output("c_rst_ready",    128'(in_ready),     128'(1));
    check_output("c_rst_busy",     128'(busy),         128'(0));
    check_output("c_rst_round",    128'(dp_round_num), 128'(0));
    check_output("c_rst_dp_state", dp_state,           128'(0));
    #1;
    rst_n = 1'b1;
    apply_stimulus(PT_B, KEY_B);
    check_output("c_accept_busy", 128'(busy), 128'(1));
    wait_for_output("c", CT_B);
    tick();
    check_output("c_ready_after", 128'(in_ready), 128'(1));

`ifdef AES_CTRL_ABORT_EN
    // Abort partway through the rounds.
    apply_stimulus(PT_A, KEY_A);
    for (int c = 1; c < 6; c++) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_output("d_abort_ready",    128'(in_ready),     128'(1));
    check_output("d_abort_busy",     128'(busy),         128'(0));
    check_output("d_abort_round",    128'(dp_round_num), 128'(0));
    check_output("d_abort_dp_state", dp_state,           128'(0));
    for (int c = 0; c < 8; c++) begin
      check_output($sformatf("d_no_valid_%0d", c), 128'(out_valid), 128'(0));
      tick();
    end

    // Abort in the same cycle as the final round.
    apply_stimulus(PT_A, KEY_A);
    for (int c = 1; c < 10; c++) tick();
    check_output("e_last_round", 128'(dp_last), 128'(1));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_output("e_abort_valid", 128'(out_valid), 128'(0));
    check_output("e_abort_ready", 128'(in_ready),  128'(1));

    // Abort while idle coinciding with a request: the request is taken.
    abort = 1'b1;
    apply_stimulus(PT_B, KEY_B);
    abort = 1'b0;
    check_output("f_accept_busy", 128'(busy), 128'(1));
    wait_for_output("f", CT_B);
    tick();
    check_output("f_ready_after", 128'(in_ready), 128'(1));
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/aes_round_ctrl.md
AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

Interface
REQ-001 Parameter NUM_ROUNDS, default 10, number of cipher rounds; legal range 1..15.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst_n  input  1  reset; one clock, reset asynchronous and active-low.
REQ-004 in_valid  input  1  request valid.
REQ-005 in_ready  output  1  controller idle and accepting a request.
REQ-006 pt  input  128  plaintext, sampled only on request handshake.
REQ-007 key  input  128  cipher key, sampled only on request handshake.
REQ-008 out_valid  output  1  ciphertext valid.
REQ-009 out_ready  input  1  consumer accepts ciphertext.
REQ-010 ct  output  128  ciphertext.
REQ-011 busy  output  1  high in RUN or DONE.
REQ-012 dp_state  output  128  state to round datapath.
REQ-013 dp_key  output  128  previous round key to datapath key generator.
REQ-014 dp_round_num  output  4  current round number, 1..NUM_ROUNDS.
REQ-015 dp_last  output  1  selects last-round datapath (no MixColumns).
REQ-016 dp_state_in  input  128  combinational round result from datapath.
REQ-017 dp_key_in  input  128  combinational round key from datapath.

Function
REQ-018 FSM states IDLE, RUN and DONE shall be implemented; the IDLE->RUN transition shall occur on in_valid&&in_ready, RUN->DONE when round==NUM_ROUNDS, and DONE->IDLE on out_valid&&out_ready.
REQ-019 in_ready shall equal (state==IDLE); in_valid outside IDLE shall be ignored, with no queuing.
REQ-020 On handshake, the block shall load state_reg<=pt^key (initial AddRoundKey), key_reg<=key, and round<=1.
REQ-021 In RUN: dp_state=state_reg, dp_key=key_reg, dp_round_num=round, dp_last=(round==NUM_ROUNDS); each cycle state_reg<=dp_state_in, key_reg<=dp_key_in, round<=round+1.
REQ-022 Outside RUN, dp_* outputs shall hold their register values and dp_last shall be 0.
REQ-023 out_valid shall be 1 exactly in DONE, with ct=state_reg; ct shall be held stable while out_valid=1 and out_ready=0.
REQ-024 Latency: handshake at cycle 0 -> out_valid first high in cycle NUM_ROUNDS+1 (11 by default); in_ready shall return the cycle after the output handshake.
REQ-025 round shall be a 4-bit counter that never exceeds NUM_ROUNDS and is not incremented outside RUN.
REQ-026 ct shall read 0 whenever out_valid=0.

Reset
REQ-027 rst_n low shall immediately force: FSM IDLE, state_reg, key_reg and round 0, in_ready 1, out_valid 0, busy 0, ct 0, dp_last 0.
REQ-028 Reset mid-operation shall discard the operation without emitting output; a new request shall be accepted on the first edge after release.

Configuration
REQ-029 With AES_CTRL_ABORT_EN defined: an input port abort (1 bit) shall exist; abort=1 in RUN or DONE shall force IDLE on the next edge, deassert out_valid, and zero state_reg/key_reg/round.
REQ-030 With AES_CTRL_ABORT_EN defined: abort shall take priority over both RUN->DONE and the output handshake, and abort in IDLE shall have no effect, including when it coincides with in_valid (the request is accepted).
REQ-031 Without AES_CTRL_ABORT_EN, the abort port shall be absent and behaviour shall be exactly REQ-018..028.

Verification (bench connects the team's round and lastround datapaths to the dp_* ports)
REQ-032 key=000102030405060708090a0b0c0d0e0f, pt=00112233445566778899aabbccddeeff -> ct=69c4e0d86a7b0430d8cdb78070b4c55a, with out_valid in cycle 11.
REQ-033 key=2b7e151628aed2a6abf7158809cf4f3c, pt=3243f6a8885a308d313198a2e0370734, out_ready held low 5 cycles -> ct=3925841d02dc09fbdc118597196a0b32, stable for all 6 valid cycles; in_ready=1 on the cycle after the output handshake.
REQ-034 Second in_valid pulse with different pt at cycle 4 of REQ-032 -> ignored; REQ-032 ct unchanged; dp_round_num sequence 1..10 and dp_last high only at round 10.
REQ-035 rst_n low at cycle 5 of REQ-032 -> out_valid=0, ct=0, in_ready=1 immediately; a new REQ-033 request after release completes correctly in 11 cycles.
REQ-036 AES_CTRL_ABORT_EN defined: abort at cycle 6 -> IDLE next edge, no out_valid; abort asserted in the same cycle as round 10 -> no out_valid.
